pc_seq_ctrl: RTL and testbench

PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

---
 rtl/pc_seq_ctrl_pkg.sv | 15 +
 rtl/pc_seq_idx.sv | 46 ++++
 rtl/pc_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_ctrl_pkg.sv
// Shared definitions for the PC-table sequencer: FSM encoding and default table depth.
// The wrap-around build option is selected with the PC_SEQ_LOOP_EN macro in pc_seq_ctrl.
package pc_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_MEM_LENGTH = 256;
  localparam int DEF_IDX_W      = $clog2(DEF_MEM_LENGTH);

endpackage

// File: rtl/pc_seq_idx.sv
// Next-index unit for pc_seq_ctrl: resolves stall > branch > end-of-table > increment
// and flags end-of-table and out-of-range branch targets.
module pc_seq_idx
  import pc_seq_ctrl_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_stall,
  input  logic             i_br_valid,
  input  logic [IDX_W-1:0] i_br_index,
  input  logic [IDX_W:0]   i_n_loaded,
  output logic [IDX_W-1:0] o_nxt_idx,
  output logic             o_end,
  output logic             o_rng_err
);

  logic w_br_ok;
  logic w_at_end;

  assign w_br_ok  = ({1'b0, i_br_index} < i_n_loaded);
  assign w_at_end = ({1'b0, i_idx} == (i_n_loaded - (IDX_W+1)'(1)));

  // priority resolution of the next table index
  always_comb begin
    o_nxt_idx = i_idx;
    o_end     = 1'b0;
    o_rng_err = 1'b0;
    if (i_stall) begin
      o_nxt_idx = i_idx;
    end else if (i_br_valid) begin
      if (w_br_ok) begin
        o_nxt_idx = i_br_index;
      end else begin
        o_nxt_idx = '0;
        o_rng_err = 1'b1;
      end
    end else if (w_at_end) begin
      o_nxt_idx = '0;
      o_end     = 1'b1;
    end else begin
      o_nxt_idx = i_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC-table load/sequence controller. Define PC_SEQ_LOOP_EN to wrap to index 0 at the
// end of the table instead of stopping in DONE.
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter int MEM_LENGTH = DEF_MEM_LENGTH,
  parameter int IDX_W      = $clog2(MEM_LENGTH)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load_valid,
  input  logic [31:0]      load_addr,
  input  logic             load_last,
  output logic             load_ready,
  input  logic             start,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [IDX_W-1:0] br_index,
  output logic             tbl_instr_en,
  output logic [31:0]      tbl_pc_adr,
  output logic             tbl_en,
  output logic [31:0]      tbl_in,
  output logic             issue_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [IDX_W:0] L_FULL = (IDX_W+1)'(MEM_LENGTH);

  state_t           r_state,  w_state_nxt;
  logic [IDX_W:0]   r_n_loaded, w_n_nxt;
  logic [IDX_W-1:0] r_idx,    w_idx_nxt;
  logic             r_err,    w_err_nxt;
  logic             r_tbl_instr_en, w_wr_nxt;
  logic [31:0]      r_tbl_pc_adr,   w_pc_nxt;
  logic             r_tbl_en,       w_en_nxt;
  logic [31:0]      r_tbl_in,       w_in_nxt;
  logic             r_issue_valid;
  logic             r_done,         w_done_nxt;
  logic [IDX_W-1:0] w_idx_calc;
  logic             w_end;
  logic             w_rng_err;
  logic             w_full;

  pc_seq_idx #(.IDX_W(IDX_W)) u_idx (
    .i_idx      (r_idx),
    .i_stall    (stall),
    .i_br_valid (br_valid),
    .i_br_index (br_index),
    .i_n_loaded (r_n_loaded),
    .o_nxt_idx  (w_idx_calc),
    .o_end      (w_end),
    .o_rng_err  (w_rng_err)
  );

  assign w_full     = (r_n_loaded == L_FULL);
  // gated by res so the handshake is dead while reset is held
  assign load_ready = res && (r_state != ST_RUN) && !w_full;

  // next-state and next-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_n_nxt     = r_n_loaded;
    w_idx_nxt   = r_idx;
    w_err_nxt   = r_err;
    w_wr_nxt    = 1'b0;
    w_pc_nxt    = r_tbl_pc_adr;
    w_en_nxt    = 1'b0;
    w_in_nxt    = r_tbl_in;
    case (r_state)
      ST_IDLE, ST_LOAD, ST_DONE: begin
        if (load_valid) begin
          if (w_full) begin
            w_err_nxt = 1'b1;
          end else begin
            w_wr_nxt = 1'b1;
            w_pc_nxt = load_addr;
            w_n_nxt  = r_n_loaded + (IDX_W+1)'(1);
            if (load_last || (w_n_nxt == L_FULL)) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt = ST_LOAD;
            end
          end
        end else if (start && (r_state != ST_LOAD)) begin
          if (r_n_loaded != '0) begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_RUN;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_RUN: begin
        w_en_nxt  = !stall;
        w_idx_nxt = w_idx_calc;
        w_err_nxt = r_err | w_rng_err;
        if (!stall) begin
          w_in_nxt = 32'(r_idx);
        end else begin
          w_in_nxt = r_tbl_in;
        end
`ifdef PC_SEQ_LOOP_EN
        w_state_nxt = ST_RUN;
`else
        if (w_end) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // done rises once the final issue has left the table pipeline
  assign w_done_nxt = (w_state_nxt == ST_DONE) && (r_state == ST_DONE) && !r_tbl_en;

  // state and registered table-side outputs
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state        <= ST_IDLE;
      r_n_loaded     <= '0;
      r_idx          <= '0;
      r_err          <= 1'b0;
      r_tbl_instr_en <= 1'b0;
      r_tbl_pc_adr   <= 32'd0;
      r_tbl_en       <= 1'b0;
      r_tbl_in       <= 32'd0;
      r_issue_valid  <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_n_loaded     <= w_n_nxt;
      r_idx          <= w_idx_nxt;
      r_err          <= w_err_nxt;
      r_tbl_instr_en <= w_wr_nxt;
      r_tbl_pc_adr   <= w_pc_nxt;
      r_tbl_en       <= w_en_nxt;
      r_tbl_in       <= w_in_nxt;
      r_issue_valid  <= r_tbl_en;
      r_done         <= w_done_nxt;
    end
  end

  assign tbl_instr_en = r_tbl_instr_en;
  assign tbl_pc_adr   = r_tbl_pc_adr;
  assign tbl_en       = r_tbl_en;
  assign tbl_in       = r_tbl_in;
  assign issue_valid  = r_issue_valid;
  assign busy         = (r_state == ST_LOAD) || (r_state == ST_RUN);
  assign done         = r_done;
  assign err          = r_err;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Randomized + directed bench for pc_seq_ctrl against a mode-level reference model.
module tb_pc_seq_ctrl;

  localparam int MEM   = 256;
  localparam int IDX_W = 8;
`ifdef PC_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_FIN = 3;

  logic             clk = 1'b0;
  logic             res = 1'b0;
  logic             load_valid = 1'b0;
  logic [31:0]      load_addr = 32'd0;
  logic             load_last = 1'b0;
  logic             load_ready;
  logic             start = 1'b0;
  logic             stall = 1'b0;
  logic             br_valid = 1'b0;
  logic [IDX_W-1:0] br_index = '0;
  logic             tbl_instr_en;
  logic [31:0]      tbl_pc_adr;
  logic             tbl_en;
  logic [31:0]      tbl_in;
  logic             issue_valid;
  logic             busy;
  logic             done;
  logic             err;

  int total = 0;
  int bad   = 0;

  // reference model: operating mode, table fill, cursor, and expected strobes
  int          m_mode, m_n, m_idx;
  bit          m_err;
  bit          e_wr, e_en, e_iv, e_done;
  logic [31:0] e_pc, e_in;

  pc_seq_ctrl #(.MEM_LENGTH(MEM), .IDX_W(IDX_W)) dut (
    .clk(clk), .res(res), .load_valid(load_valid), .load_addr(load_addr),
    .load_last(load_last), .load_ready(load_ready), .start(start), .stall(stall),
    .br_valid(br_valid), .br_index(br_index), .tbl_instr_en(tbl_instr_en),
    .tbl_pc_adr(tbl_pc_adr), .tbl_en(tbl_en), .tbl_in(tbl_in),
    .issue_valid(issue_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_n = 0; m_idx = 0; m_err = 1'b0;
    e_wr = 1'b0; e_en = 1'b0; e_iv = 1'b0; e_done = 1'b0; e_pc = 32'd0; e_in = 32'd0;
  endtask

  // one clock of the specification's rules applied to the current inputs
  task automatic model_step();
    e_iv = e_en;
    e_wr = 1'b0;
    e_en = 1'b0;
    if (m_mode != M_RUN) begin
      if (load_valid) begin
        if (m_n >= MEM) m_err = 1'b1;
        else begin
          e_wr = 1'b1; e_pc = load_addr; m_n = m_n + 1;
          m_mode = (load_last || m_n == MEM) ? M_IDLE : M_LOAD;
        end
      end else if (start && m_mode != M_LOAD) begin
        if (m_n > 0) begin m_idx = 0; m_mode = M_RUN; end
        else m_err = 1'b1;
      end
    end else if (!stall) begin
      e_en = 1'b1; e_in = 32'(m_idx);
      if (br_valid) begin
        if (int'(br_index) < m_n) m_idx = int'(br_index);
        else begin m_err = 1'b1; m_idx = 0; end
      end else if (m_idx == m_n - 1) begin
        m_idx = 0;
        if (!LOOP) m_mode = M_FIN;
      end else m_idx = m_idx + 1;
    end
    e_done = (m_mode == M_FIN) && !e_en && !e_iv;
  endtask

  task automatic cycle(input bit lv, input logic [31:0] a, input bit ll, input bit st,
                       input bit sl, input bit bv, input int bi);
    load_valid = lv; load_addr = a; load_last = ll; start = st;
    stall = sl; br_valid = bv; br_index = IDX_W'(bi);
    #1;
    check_val("load_ready", load_ready, (m_mode != M_RUN) && (m_n < MEM));
    model_step();
    @(posedge clk); #1;
    check_val("tbl_instr_en", tbl_instr_en, e_wr);
    if (e_wr) check_val("tbl_pc_adr", tbl_pc_adr, e_pc);
    check_val("tbl_en", tbl_en, e_en);
    if (e_en) check_val("tbl_in", tbl_in, e_in);
    check_val("issue_valid", issue_valid, e_iv);
    check_val("err", err, m_err);
    check_val("done", done, e_done);
    check_val("busy", busy, (m_mode == M_LOAD) || (m_mode == M_RUN));
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // asynchronous reset applied between edges; outputs must drop without a clock
  task automatic do_reset();
    #2 res = 1'b0;
    #1;
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_err", err, 1'b0);
    check_val("rst_tbl_en", tbl_en, 1'b0);
    check_val("rst_tbl_in", tbl_in, 32'd0);
    check_val("rst_issue_valid", issue_valid, 1'b0);
    check_val("rst_tbl_instr_en", tbl_instr_en, 1'b0);
    check_val("rst_tbl_pc_adr", tbl_pc_adr, 32'd0);
    check_val("rst_load_ready", load_ready, 1'b0);
    model_reset();
    @(posedge clk); #1;
    res = 1'b1;
  endtask

  // advance until the model's next issue index is target while running
  task automatic run_to_idx(input int target);
    bit reached = 1'b0;
    for (int k = 0; k < 64 && !reached; k++) begin
      if (m_mode == M_RUN && m_idx == target) reached = 1'b1;
      else if (m_mode != M_RUN) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      else idle_cycle();
    end
    check_val("reach_idx", reached, 1'b1);
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // simultaneous start and load: load wins; three-word program
    cycle(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    cycle(1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle_cycle();
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 7; i++) idle_cycle();

    // stall for two cycles with index 1 pending
    run_to_idx(1);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    idle_cycle();
    idle_cycle();

    // in-range and out-of-range branches from index 2
    run_to_idx(2);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    idle_cycle();
    run_to_idx(2);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5);
    idle_cycle();
    idle_cycle();

    // reset mid-run, then start without reloading
    run_to_idx(2);
    do_reset();
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle_cycle();

    // randomized traffic
    do_reset();
    for (int c = 0; c < 500; c++) begin
      cycle(($urandom % 5) == 0, $urandom, ($urandom % 4) == 0, ($urandom % 8) == 0,
            ($urandom % 5) == 0, ($urandom % 8) == 0, int'($urandom_range(0, 7)));
    end

    // fill the table to capacity, then overflow it
    do_reset();
    for (int w = 0; w < MEM; w++) cycle(1'b1, 32'h1000 + 32'(w * 4), 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle_cycle();
    cycle(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
